lcd_shift_rx: RTL and testbench
===============================

LCD_SHIFT_RX -- requirements
Module: lcd_shift_rx

Interface
REQ-001 SHALL have parameter SEG_W, default 64, number of segment bits in one display frame (legal range 2..256).
REQ-002 SHALL have port clk  input  1  system clock (25 MHz board clock).
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port sclk  input  1  serial shift clock from the panel display transmitter, asynchronous to clk.
REQ-005 SHALL have port sdata  input  1  serial data, sampled on sclk rising edge.
REQ-006 SHALL have port sload  input  1  latch strobe; rising edge transfers the frame.
REQ-007 SHALL have port sclr_n  input  1  active-low display clear.
REQ-008 SHALL have port seg_out  output  SEG_W  latched segment image.
REQ-009 SHALL have port frame_valid  output  1  one-cycle pulse on good latch.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on bad-length latch.
REQ-011 SHALL have port frame_cnt  output  8  count of good latches, wraps 255->0.

Function
REQ-012 SHALL pass sclk, sdata, sload and sclr_n each through a 2-flop synchronizer, plus one history flop on sclk and sload for rising-edge detection.
REQ-013 SHALL act on a pin transition on the 3rd clk rising edge after it (2 sync + 1 action register); requires sclk/sload high and low times >= 2 clk periods.
REQ-014 SHALL on each detected sclk rise shift the internal SEG_W-bit register left, with synchronized sdata entering bit 0 (first bit sent ends in seg_out[SEG_W-1]).
REQ-015 SHALL keep a bit counter cleared at each latch, incremented per sclk rise, saturating at SEG_W+1.
REQ-016 SHALL on detected sload rise with bit count == SEG_W copy the shift register to seg_out, pulse frame_valid for exactly 1 cycle, and increment frame_cnt.
REQ-017 SHALL on detected sload rise with bit count != SEG_W (short or overlong) leave seg_out and frame_cnt unchanged, pulse frame_err 1 cycle, and clear the bit counter.
REQ-018 SHALL, when sclk rise and sload rise are detected in the same cycle, latch/check using the pre-shift register and count, then apply the shift as bit 1 of the next frame (counter = 1).
REQ-019 SHALL, while synchronized sclr_n is low, hold shift register, bit counter and seg_out at zero, suppress frame_valid/frame_err, ignore sclk and sload edges; frame_cnt is not cleared.
REQ-020 SHALL give sclr_n priority over simultaneous sclk/sload edges.
REQ-021 SHALL never assert frame_valid and frame_err in the same cycle.

Reset
REQ-022 SHALL on rst_n low asynchronously clear all synchronizer/history flops, shift register, bit counter, seg_out, frame_valid, frame_err and frame_cnt to 0.
REQ-023 SHALL, on rst_n deassertion mid-frame, discard partial bits; a high sclk or sload pin at release SHALL NOT produce an edge (history flops reset to 0 but sync chain also 0, so first edge requires observed low-to-high after reset SHALL be enforced by gating edges for 3 cycles after release).
REQ-024 SHALL release reset synchronously to clk (rst_n is already synchronized by the power-on reset block).

Configuration
REQ-025 SHALL support macro LCD_RX_FRAMECHK_EN.
REQ-026 SHALL, with LCD_RX_FRAMECHK_EN defined, implement length checking per REQ-016/REQ-017.
REQ-027 SHALL, without LCD_RX_FRAMECHK_EN, omit the bit counter, tie frame_err to 0, and treat every sload rise as good (copy, pulse frame_valid, increment frame_cnt).

Verification (SEG_W=8, FRAMECHK enabled unless stated)
REQ-028 SHALL cover: shift 8'hA5 MSB-first, pulse sload -> seg_out=8'hA5, one frame_valid pulse, frame_cnt=1, 3 clk after sload edge.
REQ-029 SHALL cover: shift 7 bits then sload -> frame_err pulse, seg_out keeps prior value, frame_cnt unchanged; then 9 bits + sload -> frame_err again.
REQ-030 SHALL cover: 256 good frames -> frame_cnt wraps to 0, 256 frame_valid pulses.
REQ-031 SHALL cover: sclr_n low after 4 bits, with sload pulse during clear -> seg_out=0, no pulses; after release, full 8'h3C frame latches correctly.
REQ-032 SHALL cover: 8 bits 8'hFF, then sclk and sload rising together with sdata=0 -> seg_out=8'hFF, next 7 bits + sload latch 8'h00-based frame (counter started at 1).
REQ-033 SHALL cover: rst_n asserted mid-frame then released with sclk held high -> no spurious shift; build without macro, 5-bit frame + sload -> frame_valid, frame_err stays 0.

Source files
------------

// File: rtl/lcd_shift_rx.sv
// Serial segment receiver for the panel display link: synchronised shift and latch.
// Define LCD_RX_FRAMECHK_EN to add frame length checking and the frame_err pulse.
module lcd_shift_rx #(
    parameter int SEG_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk,
    input  logic             sdata,
    input  logic             sload,
    input  logic             sclr_n,
    output logic [SEG_W-1:0] seg_out,
    output logic             frame_valid,
    output logic             frame_err,
    output logic [7:0]       frame_cnt
);

    logic [1:0]       sclk_sy;
    logic [1:0]       sdata_sy;
    logic [1:0]       sload_sy;
    logic [1:0]       sclr_sy;
    logic             sclk_q;
    logic             sload_q;
    logic [1:0]       gate;
    logic             armed;
    logic             sclk_rise;
    logic             sload_rise;
    logic             clr;
    logic             sbit;
    logic [SEG_W-1:0] shreg;
    logic             good;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sy  <= '0;
            sdata_sy <= '0;
            sload_sy <= '0;
            sclr_sy  <= '0;
            sclk_q   <= 1'b0;
            sload_q  <= 1'b0;
            gate     <= '0;
        end else begin
            sclk_sy  <= {sclk_sy[0], sclk};
            sdata_sy <= {sdata_sy[0], sdata};
            sload_sy <= {sload_sy[0], sload};
            sclr_sy  <= {sclr_sy[0], sclr_n};
            sclk_q   <= sclk_sy[1];
            sload_q  <= sload_sy[1];
            if (gate != 2'd3) gate <= gate + 2'd1;
        end
    end

    // Pins already high at reset release must not look like fresh edges.
    assign armed      = (gate == 2'd3);
    assign sclk_rise  = armed & sclk_sy[1] & ~sclk_q;
    assign sload_rise = armed & sload_sy[1] & ~sload_q;
    assign clr        = ~sclr_sy[1];
    assign sbit       = sdata_sy[1];

`ifdef LCD_RX_FRAMECHK_EN
    localparam int CW = $clog2(SEG_W + 2);
    localparam logic [CW-1:0] FULL = CW'(SEG_W);
    localparam logic [CW-1:0] SAT  = CW'(SEG_W + 1);
    logic [CW-1:0] bit_cnt;

    assign good = (bit_cnt == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (clr) begin
                bit_cnt <= '0;
            end else if (sload_rise) begin
                frame_err <= ~good;
                bit_cnt   <= sclk_rise ? CW'(1) : '0;
            end else if (sclk_rise && bit_cnt != SAT) begin
                bit_cnt <= bit_cnt + CW'(1);
            end
        end
    end
`else
    assign good      = 1'b1;
    assign frame_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg       <= '0;
            seg_out     <= '0;
            frame_valid <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            frame_valid <= 1'b0;
            if (clr) begin
                shreg   <= '0;
                seg_out <= '0;
            end else begin
                // Latch sees the pre-shift register on a coincident sclk edge.
                if (sload_rise && good) begin
                    seg_out     <= shreg;
                    frame_valid <= 1'b1;
                    frame_cnt   <= frame_cnt + 8'd1;
                end
                if (sclk_rise) shreg <= {shreg[SEG_W-2:0], sbit};
            end
        end
    end

endmodule

// File: tb/tb_lcd_shift_rx.sv
// Bench for lcd_shift_rx at SEG_W=8 with a bit-history model of the link.
// Follows LCD_RX_FRAMECHK_EN so the same bench covers both builds.
module tb_lcd_shift_rx;

`ifdef LCD_RX_FRAMECHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       sclk = 1'b0;
    logic       sdata = 1'b0;
    logic       sload = 1'b0;
    logic       sclr_n = 1'b1;
    logic [7:0] seg_out;
    logic       frame_valid;
    logic       frame_err;
    logic [7:0] frame_cnt;

    lcd_shift_rx #(.SEG_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sclk(sclk),
        .sdata(sdata),
        .sload(sload),
        .sclr_n(sclr_n),
        .seg_out(seg_out),
        .frame_valid(frame_valid),
        .frame_err(frame_err),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int vcount = 0;
    int ecount = 0;

    // Model: every bit shifted since reset/clear, bits since last latch.
    logic       hist[$];
    int         nbits = 0;
    logic [7:0] exp_seg = '0;
    logic [7:0] exp_cnt = '0;
    logic       exp_v = 1'b0;
    logic       exp_e = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] last8();
        logic [7:0] r;
        int first;
        r = '0;
        first = (hist.size() > 8) ? hist.size() - 8 : 0;
        for (int i = first; i < hist.size(); i++) r = {r[6:0], hist[i]};
        return r;
    endfunction

    task automatic model_step(input logic crise, input logic lrise,
                              input logic d, input logic clrn);
        if (!clrn) begin
            hist.delete();
            nbits = 0;
            exp_seg = '0;
        end else begin
            if (lrise) begin
                if (!CHK || nbits == 8) begin
                    exp_seg = last8();
                    exp_cnt = exp_cnt + 8'd1;
                    exp_v = 1'b1;
                end else begin
                    exp_e = 1'b1;
                end
                nbits = 0;
            end
            if (crise) begin
                hist.push_back(d);
                nbits++;
            end
        end
    endtask

    task automatic xfer(input logic c, input logic d, input logic l,
                        input logic r);
        logic crise, lrise;
        @(negedge clk);
        crise = c & ~sclk;
        lrise = l & ~sload;
        sclk = c;
        sdata = d;
        sload = l;
        sclr_n = r;
        repeat (3) @(posedge clk);
        #1;
        model_step(crise, lrise, d, r);
        @(posedge clk);
        #1;
        exp_v = 1'b0;
        exp_e = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            xfer(1'b1, v[i], 1'b0, sclr_n);
            xfer(1'b0, v[i], 1'b0, sclr_n);
        end
    endtask

    task automatic load();
        xfer(1'b0, 1'b0, 1'b1, sclr_n);
        xfer(1'b0, 1'b0, 1'b0, sclr_n);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        hist.delete();
        nbits = 0;
        exp_seg = '0;
        exp_cnt = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(posedge clk);
            #2;
            if (frame_valid === 1'b1) vcount++;
            if (frame_err === 1'b1) ecount++;
            check("seg_out", 32'(seg_out), 32'(exp_seg));
            check("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
            check("frame_valid", 32'(frame_valid), 32'(exp_v));
            check("frame_err", 32'(frame_err), 32'(exp_e));
            check("no_dual_pulse", 32'(frame_valid & frame_err), 32'd0);
        end
    end

    initial begin
        int v0;
        #1 rst_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("lit_reset_seg", 32'(seg_out), 32'h00);
        check("lit_reset_cnt", 32'(frame_cnt), 32'd0);

        send_bits(16'hA5, 8);
        load();
        check("lit_a5_seg", 32'(seg_out), 32'hA5);
        check("lit_a5_cnt", 32'(frame_cnt), 32'd1);
        check("lit_a5_pulses", vcount, 1);

        send_bits(16'h1B, 7);
        load();
`ifdef LCD_RX_FRAMECHK_EN
        check("lit_short_err", ecount, 1);
        check("lit_short_seg", 32'(seg_out), 32'hA5);
        check("lit_short_cnt", 32'(frame_cnt), 32'd1);
`else
        check("lit_short_seg", 32'(seg_out), 32'h9B);
        check("lit_short_cnt", 32'(frame_cnt), 32'd2);
`endif
        send_bits(16'h12B, 9);
        load();
`ifdef LCD_RX_FRAMECHK_EN
        check("lit_long_err", ecount, 2);
        check("lit_long_seg", 32'(seg_out), 32'hA5);
`else
        check("lit_long_seg", 32'(seg_out), 32'h2B);
        check("lit_no_err", ecount, 0);
`endif

        send_bits(16'hF, 4);
        xfer(1'b0, 1'b0, 1'b0, 1'b0);
        v0 = vcount + ecount;
        xfer(1'b0, 1'b0, 1'b1, 1'b0);
        xfer(1'b1, 1'b1, 1'b0, 1'b0);
        xfer(1'b0, 1'b0, 1'b0, 1'b0);
        check("lit_clr_seg", 32'(seg_out), 32'h00);
        check("lit_clr_nopulse", vcount + ecount, v0);
        xfer(1'b0, 1'b0, 1'b0, 1'b1);
        send_bits(16'h3C, 8);
        load();
        check("lit_3c_seg", 32'(seg_out), 32'h3C);

        send_bits(16'hFF, 8);
        xfer(1'b1, 1'b0, 1'b1, 1'b1);
        xfer(1'b0, 1'b0, 1'b0, 1'b1);
        check("lit_coinc_seg", 32'(seg_out), 32'hFF);
        send_bits(16'h55, 7);
        load();
        check("lit_coinc_next", 32'(seg_out), 32'h55);

        send_bits(16'h5, 3);
        xfer(1'b1, 1'b1, 1'b0, 1'b1);
        do_reset();
        check("lit_mid_reset_seg", 32'(seg_out), 32'h00);
        xfer(1'b0, 1'b1, 1'b0, 1'b1);
        send_bits(16'hC3, 8);
        load();
        check("lit_c3_seg", 32'(seg_out), 32'hC3);
        check("lit_c3_cnt", 32'(frame_cnt), 32'd1);

        v0 = vcount;
        for (int i = 0; i < 255; i++) begin
            send_bits(16'(i), 8);
            load();
        end
        check("lit_wrap_cnt", 32'(frame_cnt), 32'd0);
        check("lit_wrap_seg", 32'(seg_out), 32'hFE);
        send_bits(16'h81, 8);
        load();
        check("lit_wrap_cnt1", 32'(frame_cnt), 32'd1);
        check("lit_wrap_pulses", vcount - v0, 256);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
